// File: rtl/ido_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared IDO buffer path.
// Serves CPU store path and sharpening accelerator writer in turn.
module ido_bus_arbiter #(
   parameter int DATA_W      = 16,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              REQ_CPU,
   input  logic [DATA_W-1:0] DATA_CPU,
   output logic              ACK_CPU,
   input  logic              REQ_ACC,
   input  logic [DATA_W-1:0] DATA_ACC,
   output logic              ACK_ACC,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   output logic [1:0]        GNT,
   output logic              BUSY
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              ack_cpu_q, ack_cpu_d;
   logic              ack_acc_q, ack_acc_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [3:0]        cnt_q, cnt_d;
   // last_q: 1 = accelerator served last, 0 = CPU
   logic              last_q, last_d;
   logic              cpu_win;

   assign cpu_win = REQ_CPU & (~REQ_ACC | last_q);

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      ack_cpu_d   = 1'b0;
      ack_acc_d   = 1'b0;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
            if (REQ_CPU | REQ_ACC) begin
               gnt_d       = cpu_win ? 2'b01 : 2'b10;
               out_data_d  = cpu_win ? DATA_CPU : DATA_ACC;
               out_valid_d = 1'b1;
               cnt_d       = HOLD_M1;
               state_d     = XFER;
            end
         end
         XFER: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               out_valid_d = 1'b0;
               ack_cpu_d   = gnt_q[0];
               ack_acc_d   = gnt_q[1];
               state_d     = DONE;
            end
         end
         DONE: begin
            last_d  = gnt_q[1];
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
         default: begin
            out_valid_d = 1'b0;
            gnt_d       = 2'b00;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ack_cpu_q   <= 1'b0;
         ack_acc_q   <= 1'b0;
         gnt_q       <= 2'b00;
         cnt_q       <= 4'd0;
         last_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         ack_cpu_q   <= ack_cpu_d;
         ack_acc_q   <= ack_acc_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
      end
   end

   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign ACK_CPU   = ack_cpu_q;
   assign ACK_ACC   = ack_acc_q;
   assign GNT       = gnt_q;
   assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_ido_bus_arbiter.sv
// Bench for ido_bus_arbiter: HOLD_CYCLES=2 and HOLD_CYCLES=1 builds
// driven side by side, checked against a transaction-timeline model.
module tb_ido_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rc, ra;
   logic [15:0] dc [2];
   logic [15:0] da [2];
   logic [1:0]  ack_c, ack_a, ov, busy;
   logic [15:0] od [2];
   logic [1:0]  gnt [2];

   int total = 0;
   int bad   = 0;

   // model: a transfer granted at edge st occupies edges st..st+h+1
   int          e;
   bit          act  [2];
   int          st   [2];
   bit          win  [2];
   bit          last [2];
   logic [15:0] om   [2];
   bit          cont;

   always #5 clk = ~clk;

   ido_bus_arbiter #(.DATA_W(16), .HOLD_CYCLES(2)) dut0 (
      .CLK(clk), .RESET(rst),
      .REQ_CPU(rc[0]), .DATA_CPU(dc[0]), .ACK_CPU(ack_c[0]),
      .REQ_ACC(ra[0]), .DATA_ACC(da[0]), .ACK_ACC(ack_a[0]),
      .OUT_DATA(od[0]), .OUT_VALID(ov[0]), .GNT(gnt[0]),
      .BUSY(busy[0])
   );

   ido_bus_arbiter #(.DATA_W(16), .HOLD_CYCLES(1)) dut1 (
      .CLK(clk), .RESET(rst),
      .REQ_CPU(rc[1]), .DATA_CPU(dc[1]), .ACK_CPU(ack_c[1]),
      .REQ_ACC(ra[1]), .DATA_ACC(da[1]), .ACK_ACC(ack_a[1]),
      .OUT_DATA(od[1]), .OUT_VALID(ov[1]), .GNT(gnt[1]),
      .BUSY(busy[1])
   );

   function automatic int hold(int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic chk(string tag, int i, logic [15:0] obs,
                      logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s h=%0d edge=%0d obs=%h exp=%h",
                tag, hold(i), e, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            act[i]  = 1'b0;
            last[i] = 1'b1;
            om[i]   = 16'h0;
         end else begin
            if (act[i] && e >= st[i] + hold(i) + 2) begin
               act[i]  = 1'b0;
               last[i] = win[i];
            end
            if (!act[i] && (rc[i] || ra[i])) begin
               win[i] = (rc[i] && ra[i]) ? !last[i] : ra[i];
               act[i] = 1'b1;
               st[i]  = e;
               om[i]  = win[i] ? da[i] : dc[i];
            end
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         int j;
         bit v, a, g;
         logic [1:0] eg;
         j  = e - st[i];
         v  = act[i] && j < hold(i);
         a  = act[i] && j == hold(i);
         g  = act[i] && j <= hold(i);
         eg = g ? (win[i] ? 2'b10 : 2'b01) : 2'b00;
         chk("out_valid", i, 16'(ov[i]), 16'(v));
         chk("out_data",  i, od[i], om[i]);
         chk("gnt",       i, 16'(gnt[i]), 16'(eg));
         chk("busy",      i, 16'(busy[i]), 16'(g));
         chk("ack_cpu",   i, 16'(ack_c[i]), 16'(a && !win[i]));
         chk("ack_acc",   i, 16'(ack_a[i]), 16'(a && win[i]));
      end
   endtask

   // one clock: predict, advance, check, then requesters react to ACK
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      e++;
      for (int i = 0; i < 2; i++) begin
         if (ack_c[i]) begin
            rc[i] = cont;
            if (cont) dc[i] = 16'($urandom);
         end
         if (ack_a[i]) begin
            ra[i] = cont;
            if (cont) da[i] = 16'($urandom);
         end
      end
   endtask

   task automatic steps(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      e    = 0;
      cont = 1'b0;
      rst  = 1'b1;
      rc   = 2'b00;
      ra   = 2'b00;
      for (int i = 0; i < 2; i++) begin
         dc[i] = 16'h0; da[i] = 16'h0;
         act[i] = 1'b0; st[i] = 0; win[i] = 1'b0;
         last[i] = 1'b1; om[i] = 16'h0;
      end
      steps(2);
      rst = 1'b0;
      steps(1);

      // single CPU request
      rc = 2'b11;
      dc[0] = 16'hA5A5; dc[1] = 16'hBEEF;
      steps(6);

      // simultaneous requests: CPU wins first tie
      rc = 2'b11; ra = 2'b11;
      dc[0] = 16'h1111; dc[1] = 16'h1111;
      da[0] = 16'h2222; da[1] = 16'h2222;
      steps(12);

      // continuous re-requests alternate
      cont = 1'b1;
      rc = 2'b11; ra = 2'b11;
      steps(26);
      cont = 1'b0;
      steps(10);
      rc = 2'b00; ra = 2'b00;
      steps(2);

      // data change and request drop during XFER
      ra = 2'b11;
      da[0] = 16'h00FF; da[1] = 16'h00FF;
      steps(1);
      da[0] = 16'hFFFF; da[1] = 16'hFFFF;
      ra = 2'b00;
      steps(5);

      // reset in the second XFER cycle
      rc = 2'b11;
      dc[0] = 16'h1234; dc[1] = 16'h1234;
      steps(2);
      rst = 1'b1;
      steps(1);
      rst = 1'b0;
      rc = 2'b00;
      steps(4);
      rc = 2'b11;
      dc[0] = 16'h5678; dc[1] = 16'h5678;
      steps(6);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         cont = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++) begin
            if (!rc[i] && $urandom_range(0, 2) == 0) begin
               rc[i] = 1'b1; dc[i] = 16'($urandom);
            end
            if (!ra[i] && $urandom_range(0, 2) == 0) begin
               ra[i] = 1'b1; da[i] = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) dc[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) da[i] = 16'($urandom);
            if ($urandom_range(0, 19) == 0) rc[i] = 1'b0;
            if ($urandom_range(0, 19) == 0) ra[i] = 1'b0;
         end
         step();
      end
      rst = 1'b0;
      steps(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
